// File: rtl/timing_pkg.sv
// Shared types and helpers for the periodic-tick producer/consumer modules.
package timing_pkg;

    typedef enum logic [1:0] {
        PM_IDLE,
        PM_RUN,
        PM_TIMEOUT
    } pm_state_t;

    // Bits needed to hold any value in 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pulse_period_monitor.sv
// Measures clocks between single-cycle strobes, flags early/late intervals and
// reports lock after a run of in-range intervals. All outputs registered.
module pulse_period_monitor
    import timing_pkg::*;
#(
    parameter int expected_count = 6_000_000,
    parameter int tolerance      = 1000,
    parameter int lock_count     = 4,
    localparam int W             = cnt_width(expected_count + tolerance)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         pulse,
    output logic [W-1:0] period,
    output logic         period_valid,
    output logic         early,
    output logic         timeout,
    output logic         locked
);

    localparam int GW = cnt_width(lock_count);
    localparam logic [W-1:0]  MAX_C  = W'(expected_count + tolerance);
    localparam logic [W-1:0]  MIN_C  = W'(expected_count - tolerance);
    localparam logic [W-1:0]  ONE    = W'(1);
    localparam logic [GW-1:0] LOCK_N = GW'(lock_count);

    if (expected_count < 2) begin : g_bad_expected
        $error("pulse_period_monitor: expected_count must be >= 2");
    end
    if (tolerance < 0 || tolerance >= expected_count) begin : g_bad_tolerance
        $error("pulse_period_monitor: tolerance must be in [0, expected_count)");
    end
    if (lock_count < 1) begin : g_bad_lock
        $error("pulse_period_monitor: lock_count must be >= 1");
    end

    pm_state_t     state_q, state_d;
    logic [W-1:0]  count_q, count_d;
    logic [W-1:0]  period_q, period_d;
    logic          period_valid_q, period_valid_d;
    logic          early_q, early_d;
    logic          timeout_q, timeout_d;
    logic          locked_q, locked_d;
    logic [GW-1:0] good_q, good_d;

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        early_d        = early_q;
        timeout_d      = 1'b0;
        good_d         = good_q;

        if (clear) begin
            state_d  = PM_IDLE;
            count_d  = '0;
            period_d = '0;
            early_d  = 1'b0;
            good_d   = '0;
        end else begin
            unique case (state_q)
                PM_IDLE, PM_TIMEOUT: begin
                    // No trusted reference: a pulse only restarts timing.
                    if (pulse) begin
                        state_d = PM_RUN;
                        count_d = ONE;
                    end
                end
                PM_RUN: begin
                    if (pulse) begin
                        period_d       = count_q;
                        period_valid_d = 1'b1;
                        early_d        = (count_q < MIN_C);
                        count_d        = ONE;
                        if (count_q < MIN_C) begin
                            good_d = '0;
                        end else if (good_q != LOCK_N) begin
                            good_d = good_q + GW'(1);
                        end
                    end else if (count_q == MAX_C) begin
                        timeout_d = 1'b1;
                        good_d    = '0;
                        state_d   = PM_TIMEOUT;
                    end else begin
                        count_d = count_q + ONE;
                    end
                end
                default: begin
                    state_d = PM_IDLE;
                    count_d = '0;
                    good_d  = '0;
                end
            endcase
        end

        locked_d = (good_d == LOCK_N);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= PM_IDLE;
            count_q        <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            early_q        <= 1'b0;
            timeout_q      <= 1'b0;
            locked_q       <= 1'b0;
            good_q         <= '0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            early_q        <= early_d;
            timeout_q      <= timeout_d;
            locked_q       <= locked_d;
            good_q         <= good_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign early        = early_q;
    assign timeout      = timeout_q;
    assign locked       = locked_q;

endmodule
